voice_osc_mixer: RTL

Time-multiplexed multi-voice oscillator and mixer that consumes the sample-rate tick from the sample-rate counter. On each tick it advances every voice's phase accumulator and computes each voice's waveform value. It then sums the voices, scales the sum and presents one signed audio sample with a valid strobe to the downstream output stage (PWM/DAC driver). One voice is processed per clock, so the block uses a single shared waveform/adder datapath.

---
 rtl/voice_osc_mixer.sv | 128 ++++++++++++
 1 files changed

// File: rtl/voice_osc_mixer.sv
// Time-multiplexed multi-voice oscillator and mixer.
// One voice per clock through a shared waveform/adder datapath.
module voice_osc_mixer #(
    parameter int NUM_VOICES = 4,
    parameter int PHASE_W    = 24,
    parameter int SAMPLE_W   = 16
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic                           sample_tick,
    input  logic [NUM_VOICES-1:0]          voice_en,
    input  logic [NUM_VOICES*PHASE_W-1:0]  phase_inc,
    input  logic [NUM_VOICES*2-1:0]        wave_sel,
    output logic [SAMPLE_W-1:0]            sample_out,
    output logic                           sample_valid,
    output logic                           busy,
    output logic                           overrun
);

    localparam int VIDX_W = $clog2(NUM_VOICES);
    localparam int ACC_W  = SAMPLE_W + VIDX_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        SCALE = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic [VIDX_W-1:0]          idx_q, idx_d;
    logic signed [ACC_W-1:0]    acc_q, acc_d;
    logic [PHASE_W-1:0]         phase_q [NUM_VOICES];
    logic [PHASE_W-1:0]         phase_d [NUM_VOICES];
    logic [SAMPLE_W-1:0]        sample_out_q, sample_out_d;
    logic                       valid_q, valid_d;
    logic                       overrun_q, overrun_d;

    logic                       cur_en;
    logic [PHASE_W-1:0]         cur_phase;
    logic [PHASE_W-1:0]         cur_inc;
    logic [1:0]                 cur_sel;
    logic [SAMPLE_W-1:0]        p;
    logic [SAMPLE_W-2:0]        tri_u;
    logic signed [SAMPLE_W-1:0] voice_val;

    // Shared waveform generator for the voice selected by idx_q
    always_comb begin
        cur_en    = voice_en[idx_q];
        cur_phase = phase_q[idx_q];
        cur_inc   = phase_inc[idx_q*PHASE_W +: PHASE_W];
        cur_sel   = wave_sel[idx_q*2 +: 2];
        p         = cur_phase[PHASE_W-1 -: SAMPLE_W];
        tri_u     = p[SAMPLE_W-1] ? ~p[SAMPLE_W-2:0] : p[SAMPLE_W-2:0];
        voice_val = '0;
        if (cur_en) begin
            unique case (cur_sel)
                2'b00: voice_val = p[SAMPLE_W-1]
                    ? {1'b1, {(SAMPLE_W-2){1'b0}}, 1'b1}
                    : {1'b0, {(SAMPLE_W-1){1'b1}}};
                2'b01: voice_val = {~p[SAMPLE_W-1], p[SAMPLE_W-2:0]};
                2'b10: voice_val = {~tri_u[SAMPLE_W-2],
                                    tri_u[SAMPLE_W-3:0], 1'b0};
                default: voice_val = '0;
            endcase
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        acc_d        = acc_q;
        phase_d      = phase_q;
        sample_out_d = sample_out_q;
        valid_d      = 1'b0;
        overrun_d    = overrun_q | (sample_tick && (state_q != IDLE));
        unique case (state_q)
            IDLE: begin
                if (sample_tick) begin
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                acc_d          = acc_q + ACC_W'(voice_val);
                phase_d[idx_q] = cur_en ? cur_phase + cur_inc : '0;
                idx_d          = idx_q + VIDX_W'(1);
                if (idx_q == VIDX_W'(NUM_VOICES-1)) begin
                    state_d = SCALE;
                end
            end
            SCALE: begin
                sample_out_d = SAMPLE_W'(acc_q >>> VIDX_W);
                valid_d      = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            acc_q        <= '0;
            sample_out_q <= '0;
            valid_q      <= 1'b0;
            overrun_q    <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                phase_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            acc_q        <= acc_d;
            sample_out_q <= sample_out_d;
            valid_q      <= valid_d;
            overrun_q    <= overrun_d;
            phase_q      <= phase_d;
        end
    end

    assign sample_out   = sample_out_q;
    assign sample_valid = valid_q;
    assign busy         = (state_q != IDLE);
    assign overrun      = overrun_q;

endmodule
